vga_draw_arbiter: RTL and testbench
===================================

Name: vga_draw_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, plot) between NUM_REQ full-frame or region draw engines: background, sprites, stage-clear banners, and similar.
- Each engine raises a request. The arbiter grants one engine at a time in round-robin order and asserts that engine's enable until the engine reports done.
- It muxes the granted engine's pixel stream onto the VGA port and gates plot to cover the engines' ROM read latency.
- Sits between the game FSM, the draw_* engines and the VGA adapter.

Parameters:
- NUM_REQ, 4, number of draw engines (2..8).
- START_LATENCY, 2, cycles after enable rises before the engine's x/y/colour are valid (1 enable-to-counter delay + 1 ROM read).
- TIMEOUT_CYCLES, 16384, max cycles a grant may be held without done before forced release.
- TW, 15, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req  in  NUM_REQ  request per engine; level, held until its done is seen
- eng_done  in  NUM_REQ  per-engine done flag (level or pulse)
- eng_x  in  8*NUM_REQ  packed engine x, engine i at bits [8i+7:8i]
- eng_y  in  7*NUM_REQ  packed engine y
- eng_colour  in  9*NUM_REQ  packed engine colour
- eng_enable  out  NUM_REQ  one-hot enable to the granted engine
- grant_done  out  NUM_REQ  one-cycle pulse when engine i's job completes or times out
- timeout_err  out  1  sticky flag, set on any forced release
- busy  out  1  high while in any state other than IDLE
- vga_x  out  8  to VGA adapter
- vga_y  out  7  to VGA adapter
- vga_colour  out  9  to VGA adapter
- vga_plot  out  1  VGA write enable

Behaviour:
- Reset: clk and resetn (synchronous, active-low) as stated. All outputs go to 0. State=IDLE, last-grant pointer=NUM_REQ-1 (so engine 0 has priority first), latency and timeout counters cleared. Reset mid-grant drops eng_enable the same edge. Pixels already written are not undone.
- States:
  - IDLE: if any req, select the first set req scanning from (last+1) mod NUM_REQ upward with wrap. Register grant index, go to ARM. Else stay.
  - ARM: eng_enable[g]=1. Latency counter counts 0..START_LATENCY-1, then go to DRAW. vga_plot=0 throughout.
  - DRAW: eng_enable[g]=1, vga_plot=1. vga_x/y/colour = engine g's fields, combinational mux on registered index. Each cycle, increment timeout counter.
  - RELEASE: one cycle. eng_enable=0, vga_plot=0, grant_done[g]=1, last=g. Next state IDLE.
- DRAW exit conditions, checked in this order:
  - eng_done[g]=1 -> RELEASE. The pixel presented in that same cycle is plotted.
  - timeout counter reaches TIMEOUT_CYCLES-1 -> RELEASE and set timeout_err.
- eng_done[g] asserted during ARM -> ignored. It is a stale level from the previous job, because engines clear done only at their first pixel.
- eng_done of non-granted engines: ignored.
- req[g] dropping mid-grant: no effect; the job runs to done or timeout.
- Minimum gap between grants: RELEASE + IDLE = 2 cycles with vga_plot=0.
- A single requester re-requesting is re-granted after that gap. Round-robin prevents starvation: with all req high, order is 0,1,2,3,0,…
- timeout_err clears only on reset.
- busy = (state != IDLE).
- vga_* outputs are 0 whenever state != DRAW.

Test Plan:
- Reset then req=4'b0001; engine 0 raises done 3200+2 cycles after enable -> eng_enable[0] high from cycle 1, vga_plot high exactly 3201 cycles, grant_done[0] pulses once, busy returns low.
- req=4'b1111 held, each engine done after 10 DRAW cycles -> grants in order 0,1,2,3,0. Exactly 2 idle cycles with vga_plot=0 between grants.
- Engine 2 granted with eng_x slice=8'd39, eng_y=7'd39, colour=9'h1FF during DRAW -> vga_x=39, vga_y=39, vga_colour=9'h1FF, plot=1. Other slices' values never appear on the port.
- Stale eng_done[1]=1 held through ARM, dropped at first DRAW cycle, re-raised 5 cycles later -> no release during ARM; release after the 5th DRAW cycle.
- TIMEOUT_CYCLES=16, done never raised -> RELEASE after 16 DRAW cycles, timeout_err=1 sticky, next requester granted.
- resetn=0 for one cycle mid-DRAW -> next edge: all outputs 0, state IDLE. After release, req=4'b0011 grants engine 0 first.

Source files
------------

// File: rtl/vga_draw_arbiter_if.sv
// Engine-side request/pixel bus and VGA adapter write port of the draw arbiter.
// The master modport is the arbiter; the slave modport is the engines/adapter side.
interface vga_draw_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   eng_done;
    logic [8*NUM_REQ-1:0] eng_x;
    logic [7*NUM_REQ-1:0] eng_y;
    logic [9*NUM_REQ-1:0] eng_colour;
    logic [NUM_REQ-1:0]   eng_enable;
    logic [NUM_REQ-1:0]   grant_done;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [8:0]           vga_colour;
    logic                 vga_plot;

    modport master (
        input  req, eng_done, eng_x, eng_y, eng_colour,
        output eng_enable, grant_done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        output req, eng_done, eng_x, eng_y, eng_colour,
        input  eng_enable, grant_done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port between draw engines,
// hiding each engine's start-up latency and forcing release of hung jobs.
module vga_draw_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned START_LATENCY  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16384,
    parameter int unsigned TW             = 15
) (
    input  logic                clk,
    input  logic                resetn,
    vga_draw_arbiter_if.master  bus,
    output logic                timeout_err,
    output logic                busy
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LW = (START_LATENCY > 1) ? $clog2(START_LATENCY) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);
    localparam logic [LW-1:0] LAT_END  = LW'(START_LATENCY - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_DRAW, ST_RELEASE} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_q, last_d;
    logic [GW-1:0]      pick;
    logic               found;
    logic [LW-1:0]      lat_q, lat_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               tmo_err_q, tmo_err_d;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] en_q, gdone_q;
    logic               plot_q, busy_q;
    logic [7:0]         vx;
    logic [6:0]         vy;
    logic [8:0]         vc;

    // First pending request scanning upward from the engine after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!found && bus.req[GW'((32'(last_q) + i) % NUM_REQ)]) begin
                found = 1'b1;
                pick  = GW'((32'(last_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        lat_d     = lat_q;
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
        case (state_q)
            ST_IDLE: begin
                lat_d = '0;
                tmo_d = '0;
                if (found) begin
                    grant_d = pick;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // A done seen here is left over from the engine's previous job.
                if (lat_q == LAT_END) begin
                    lat_d   = '0;
                    state_d = ST_DRAW;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_DRAW: begin
                if (bus.eng_done[grant_q]) begin
                    state_d = ST_RELEASE;
                end else if (tmo_q == TMO_END) begin
                    state_d   = ST_RELEASE;
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RELEASE: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = (grant_d == GW'(i));
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= LAST_RST;
            lat_q     <= '0;
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
            en_q      <= '0;
            gdone_q   <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            lat_q     <= lat_d;
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
            en_q      <= (state_d == ST_ARM || state_d == ST_DRAW) ? grant_oh : '0;
            gdone_q   <= (state_d == ST_RELEASE) ? grant_oh : '0;
            plot_q    <= (state_d == ST_DRAW);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // Pixel mux on the registered grant, forced to zero outside DRAW.
    always_comb begin
        vx = '0;
        vy = '0;
        vc = '0;
        if (state_q == ST_DRAW) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_q == GW'(i)) begin
                    vx = bus.eng_x[8*i +: 8];
                    vy = bus.eng_y[7*i +: 7];
                    vc = bus.eng_colour[9*i +: 9];
                end
            end
        end
    end

    assign bus.eng_enable = en_q;
    assign bus.grant_done = gdone_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = vx;
    assign bus.vga_y      = vy;
    assign bus.vga_colour = vc;
    assign timeout_err    = tmo_err_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: long job, round-robin order, pixel mux,
// stale done, timeout (short-timeout instance) and mid-draw reset.
module tb_vga_draw_arbiter;
    logic clk;
    logic resetn;
    logic terr1, busy1, terr2, busy2;
    int   total = 0;
    int   bad   = 0;

    vga_draw_arbiter_if #(.NUM_REQ(4)) b1 ();
    vga_draw_arbiter_if #(.NUM_REQ(4)) b2 ();

    vga_draw_arbiter #(.NUM_REQ(4), .START_LATENCY(2), .TIMEOUT_CYCLES(16384), .TW(15)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1), .timeout_err(terr1), .busy(busy1));

    vga_draw_arbiter #(.NUM_REQ(4), .START_LATENCY(2), .TIMEOUT_CYCLES(16), .TW(5)) dut2 (
        .clk(clk), .resetn(resetn), .bus(b2), .timeout_err(terr2), .busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) begin
            if (v == (4'b0001 << i)) r = i;
        end
        return r;
    endfunction

    initial begin
        int plots, gd, dcnt, gap, ngr, fin, arm_cyc, terr_mid;
        int ord[5];
        int gaps[4];
        int pcs[5];
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        logic [3:0] en, prev;

        resetn = 1'b0;
        b1.req = '0; b1.eng_done = '0;
        b2.req = '0; b2.eng_done = '0;
        for (int i = 0; i < 4; i++) begin
            b1.eng_x[8*i +: 8]      = 8'hC0 + 8'(i);
            b1.eng_y[7*i +: 7]      = 7'h50 + 7'(i);
            b1.eng_colour[9*i +: 9] = 9'h020 + 9'(i);
        end
        b1.eng_x[23:16]      = 8'd39;
        b1.eng_y[20:14]      = 7'd39;
        b1.eng_colour[26:18] = 9'h1FF;
        b2.eng_x = b1.eng_x; b2.eng_y = b1.eng_y; b2.eng_colour = b1.eng_colour;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_enable", 32'(b1.eng_enable), 0);
        check("rst_plot", 32'(b1.vga_plot), 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_grant_done", 32'(b1.grant_done), 0);
        check("rst_pixel", 32'({b1.vga_x, b1.vga_y, b1.vga_colour}), 0);
        check("rst_timeout_err", 32'(terr1), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Long job on engine 0: done raised 3202 cycles after enable
        b1.req = 4'b0001;
        @(negedge clk);
        check("t1_enable_first", 32'(b1.eng_enable), 1);
        check("t1_plot_in_arm", 32'(b1.vga_plot), 0);
        plots = 0; gd = 0; fin = 0;
        for (int c = 1; c < 4000; c++) begin
            @(negedge clk);
            if (b1.vga_plot) plots++;
            if (b1.grant_done[0]) gd++;
            if (c == 3202) begin
                b1.eng_done[0] = 1'b1;
                b1.req = '0;
            end
            if (!busy1) begin fin = 1; break; end
        end
        check("t1_finished", 32'(fin), 1);
        check("t1_plot_cycles", 32'(plots), 3201);
        check("t1_grant_done_pulses", 32'(gd), 1);
        check("t1_enable_off", 32'(b1.eng_enable), 0);
        b1.eng_done = '0;

        // All engines requesting, 10 DRAW cycles each: order 0,1,2,3,0
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        b1.req = 4'b1111;
        ngr = 0; gap = 0; prev = '0; dcnt = 0; fin = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            en = b1.eng_enable;
            if (en != 0 && prev == 0) begin
                if (ngr < 5) ord[ngr] = oh2idx(en);
                if (ngr > 0 && ngr < 5) gaps[ngr-1] = gap;
                ngr++;
                dcnt = 0;
            end
            gap  = (en == 0) ? gap + 1 : 0;
            prev = en;
            if (b1.vga_plot) begin
                dcnt++;
                if (dcnt == 10) b1.eng_done = en;
            end
            if (b1.grant_done != 0) begin
                if (ngr >= 1 && ngr <= 5) pcs[ngr-1] = dcnt;
                b1.eng_done = '0;
                if (ngr >= 5) b1.req = '0;
            end
            if (ngr >= 5 && b1.req == 0 && !busy1) begin fin = 1; break; end
        end
        check("t2_finished", 32'(fin), 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_order%0d", k), 32'(ord[k]), 32'(exp_ord[k]));
            check($sformatf("t2_draw_cycles%0d", k), 32'(pcs[k]), 10);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_gap%0d", k), 32'(gaps[k]), 2);
        end

        // Engine 2 pixel stream reaches the port; zeros outside DRAW
        b1.req = 4'b0100;
        dcnt = 0; fin = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (b1.vga_plot) begin
                dcnt++;
                check("t3_pixel", 32'({b1.vga_x, b1.vga_y, b1.vga_colour}),
                      32'({8'd39, 7'd39, 9'h1FF}));
                if (dcnt == 3) b1.eng_done[2] = 1'b1;
            end else begin
                check("t3_quiet", 32'({b1.vga_x, b1.vga_y, b1.vga_colour}), 0);
            end
            if (b1.grant_done != 0) begin
                check("t3_grant_done", 32'(b1.grant_done), 32'(4'b0100));
                b1.eng_done = '0;
                b1.req = '0;
            end
            if (!busy1 && dcnt > 0) begin fin = 1; break; end
        end
        check("t3_finished", 32'(fin), 1);
        check("t3_draw_cycles", 32'(dcnt), 3);

        // Stale done on engine 1 held through ARM
        b1.req = 4'b0010;
        b1.eng_done[1] = 1'b1;
        dcnt = 0; gd = 0; arm_cyc = 0; fin = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (b1.eng_enable != 0 && !b1.vga_plot) arm_cyc++;
            if (b1.vga_plot) begin
                dcnt++;
                if (dcnt == 1) b1.eng_done[1] = 1'b0;
                if (dcnt == 5) b1.eng_done[1] = 1'b1;
            end
            if (b1.grant_done != 0) begin
                gd++;
                b1.eng_done = '0;
                b1.req = '0;
            end
            if (!busy1 && gd > 0) begin fin = 1; break; end
        end
        check("t4_finished", 32'(fin), 1);
        check("t4_arm_cycles", 32'(arm_cyc), 2);
        check("t4_draw_cycles", 32'(dcnt), 5);
        check("t4_grant_done_pulses", 32'(gd), 1);
        check("t4_timeout_err", 32'(terr1), 0);

        // Timeout instance: no done ever, engines 0 then 1 forced out after 16 cycles
        b2.req = 4'b0011;
        ngr = 0; prev = '0; dcnt = 0; fin = 0; terr_mid = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            en = b2.eng_enable;
            if (en != 0 && prev == 0) begin
                if (ngr < 2) ord[ngr] = oh2idx(en);
                ngr++;
                dcnt = 0;
                if (ngr == 2) b2.req = '0;
            end
            prev = en;
            if (b2.vga_plot) begin
                dcnt++;
                if (ngr == 1 && dcnt == 1) terr_mid = 32'(terr2);
            end
            if (b2.grant_done != 0 && ngr >= 1 && ngr <= 2) pcs[ngr-1] = dcnt;
            if (ngr >= 2 && b2.req == 0 && !busy2) begin fin = 1; break; end
        end
        check("t5_finished", 32'(fin), 1);
        check("t5_err_before", 32'(terr_mid), 0);
        check("t5_order0", 32'(ord[0]), 0);
        check("t5_order1", 32'(ord[1]), 1);
        check("t5_draw_cycles0", 32'(pcs[0]), 16);
        check("t5_draw_cycles1", 32'(pcs[1]), 16);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", 32'(terr2), 1);

        // Reset mid-DRAW, then engine 0 wins first again
        b1.req = 4'b0001;
        fin = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b1.vga_plot) begin fin = 1; break; end
        end
        check("t6_reached_draw", 32'(fin), 1);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("t6_enable", 32'(b1.eng_enable), 0);
        check("t6_plot", 32'(b1.vga_plot), 0);
        check("t6_busy", 32'(busy1), 0);
        check("t6_grant_done", 32'(b1.grant_done), 0);
        check("t6_pixel", 32'({b1.vga_x, b1.vga_y, b1.vga_colour}), 0);
        check("t6_timeout_err_cleared", 32'(terr2), 0);
        resetn = 1'b1;
        b1.req = 4'b0011;
        @(negedge clk);
        check("t6_first_grant", 32'(b1.eng_enable), 1);
        b1.req = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
